// File: rtl/dsp_rx_boxcar_decim.sv
// RX output stage: I/Q swap/real-mode mux, boxcar integrate-and-dump decimation,
// shift/round/saturate. Define RX_OVF_COUNT_EN to put an overflow event counter in debug[31:16].
module dsp_rx_boxcar_decim #(
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int RATE_BITS = 8,
    parameter int BASE      = 160
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_stb,
    input  logic [7:0]             set_addr,
    input  logic [31:0]            set_data,
    input  logic                   run,
    input  logic [WIDTH_IN-1:0]    in_i,
    input  logic [WIDTH_IN-1:0]    in_q,
    input  logic                   in_stb,
    input  logic                   adc_ovf_i,
    input  logic                   adc_ovf_q,
    output logic [2*WIDTH_OUT-1:0] sample,
    output logic                   strobe,
    output logic                   overflow,
    output logic [31:0]            debug
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 3;
    localparam int AW        = WIDTH_IN + RATE_BITS;
    localparam int SW        = AW + 1;

    logic [RATE_BITS-1:0] rate;
    logic [4:0]           shift;
    logic                 realmode;
    logic                 swap_iq;
    logic                 wr_rate;
    logic                 wr_clr;

    assign wr_rate = set_stb && (set_addr == 8'(BASE));
    assign wr_clr  = set_stb && (set_addr == 8'(BASE + 3));

    always_ff @(posedge clk) begin
        if (rst) begin
            rate     <= '0;
            shift    <= '0;
            realmode <= 1'b0;
            swap_iq  <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == 8'(BASE))     rate  <= set_data[RATE_BITS-1:0];
            if (set_addr == 8'(BASE + 1)) shift <= set_data[4:0];
            if (set_addr == 8'(BASE + 2)) {realmode, swap_iq} <= set_data[1:0];
        end
    end

    logic unused_set;
    assign unused_set = ^set_data[31:RATE_BITS];

    // Stage 1: lane 0 is I, lane 1 is Q
    logic [NUM_LANES-1:0][WIDTH_IN-1:0] s1_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x <= '0;
        end else if (in_stb) begin
            s1_x[0] <= swap_iq ? in_q : in_i;
            s1_x[1] <= realmode ? '0 : (swap_iq ? in_i : in_q);
        end
    end

    // Block counter shared by both lanes; rate 0 behaves as rate 1
    logic [RATE_BITS-1:0] cnt;
    logic [RATE_BITS-1:0] last_idx;
    logic                 last;
    logic [STAGES-1:0]    vld_pipe;
    logic                 flush;
    logic                 ld_en;

    assign last_idx = (rate == '0) ? '0 : rate - 1'b1;
    assign last     = (cnt == last_idx);
    assign flush    = !run || wr_rate;
    assign ld_en    = vld_pipe[1] && run;

    always_ff @(posedge clk) begin
        if (rst || flush)     cnt <= '0;
        else if (vld_pipe[0]) cnt <= last ? '0 : cnt + 1'b1;
    end

    // A rate write drops the partial block but lets a pending dump finish in stage 3
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_stb;
            vld_pipe[1] <= vld_pipe[0] && last && !wr_rate;
            vld_pipe[2] <= vld_pipe[1];
        end
    end

    logic [NUM_LANES-1:0][WIDTH_OUT-1:0] lane_y;
    logic [NUM_LANES-1:0]                lane_sat;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [AW-1:0]    acc;
        logic signed [AW-1:0]    dump;
        logic signed [AW-1:0]    xe;
        logic signed [SW-1:0]    rnd;
        logic signed [SW-1:0]    sum;
        logic signed [SW-1:0]    r;
        logic signed [SW-1:0]    max_v;
        logic signed [SW-1:0]    min_v;
        logic                    sat_hi;
        logic                    sat_lo;
        logic [WIDTH_OUT-1:0]    y_next;
        logic [WIDTH_OUT-1:0]    y;

        assign xe = {{RATE_BITS{s1_x[g][WIDTH_IN-1]}}, s1_x[g]};

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                acc <= '0;
            end else if (vld_pipe[0]) begin
                acc <= last ? '0 : acc + xe;
            end
        end

        always_ff @(posedge clk) begin
            if (rst)                                   dump <= '0;
            else if (vld_pipe[0] && last && !flush)    dump <= acc + xe;
        end

        // One extra bit so the rounding constant cannot wrap the largest dump
        assign rnd   = (shift == 5'd0) ? '0 : (SW'(1) << (shift - 5'd1));
        assign sum   = {dump[AW-1], dump} + rnd;
        assign r     = sum >>> shift;
        assign max_v = {{(SW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
        assign min_v = {{(SW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
        assign sat_hi = (r > max_v);
        assign sat_lo = (r < min_v);

        always_comb begin
            y_next = r[WIDTH_OUT-1:0];
            if (sat_hi)      y_next = max_v[WIDTH_OUT-1:0];
            else if (sat_lo) y_next = min_v[WIDTH_OUT-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst)        y <= '0;
            else if (ld_en) y <= y_next;
        end

        assign lane_y[g]   = y;
        assign lane_sat[g] = sat_hi || sat_lo;
    end

    assign sample = {lane_y[0], lane_y[1]};
    assign strobe = vld_pipe[2] && run;

    logic ovf_set;
    assign ovf_set = (ld_en && (|lane_sat)) || (in_stb && (adc_ovf_i || adc_ovf_q));

    always_ff @(posedge clk) begin
        if (rst)          overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (wr_clr)  overflow <= 1'b0;
    end

    logic [31:0] dbg_base;
    assign dbg_base = {strobe, run, overflow, rate, {(29-RATE_BITS){1'b0}}};

`ifdef RX_OVF_COUNT_EN
    logic [15:0] ovf_cnt;
    logic        unused_dbg;

    // A clear coinciding with a new event leaves that event counted
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_set) begin
            if (wr_clr)                  ovf_cnt <= 16'd1;
            else if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end else if (wr_clr) begin
            ovf_cnt <= '0;
        end
    end

    assign unused_dbg = ^dbg_base[31:16];
    assign debug      = {ovf_cnt, dbg_base[15:0]};
`else
    assign debug = dbg_base;
`endif

endmodule

// File: tb/tb_dsp_rx_boxcar_decim.sv
// Directed bench for dsp_rx_boxcar_decim: latency, decimation sums, rounding,
// saturation/overflow, real-mode/swap, run flush and gapped input.
module tb_dsp_rx_boxcar_decim;
    localparam int WI   = 24;
    localparam int WO   = 16;
    localparam int RB   = 8;
    localparam int BASE = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic          run;
    logic [WI-1:0] in_i;
    logic [WI-1:0] in_q;
    logic          in_stb;
    logic          adc_ovf_i;
    logic          adc_ovf_q;
    logic [2*WO-1:0] sample;
    logic          strobe;
    logic          overflow;
    logic [31:0]   debug;

    int n_vec  = 0;
    int n_err  = 0;
    int n_strb = 0;
    int base_strb;

    dsp_rx_boxcar_decim #(
        .WIDTH_IN(WI), .WIDTH_OUT(WO), .RATE_BITS(RB), .BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .run(run), .in_i(in_i), .in_q(in_q), .in_stb(in_stb),
        .adc_ovf_i(adc_ovf_i), .adc_ovf_q(adc_ovf_q),
        .sample(sample), .strobe(strobe), .overflow(overflow), .debug(debug)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (strobe) n_strb++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = data;
        step();
        set_stb  = 1'b0;
    endtask

    // Returns just after the edge that samples the last input
    task automatic feed(input int n, input logic [WI-1:0] vi, input logic [WI-1:0] vq, input int gap);
        for (int k = 0; k < n; k++) begin
            in_i   = vi;
            in_q   = vq;
            in_stb = 1'b1;
            step();
            in_stb = 1'b0;
            repeat (gap) step();
        end
    endtask

    initial begin
        rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0; run = 1'b0;
        in_i = '0; in_q = '0; in_stb = 1'b0; adc_ovf_i = 1'b0; adc_ovf_q = 1'b0;
        repeat (3) step();
        chk("rst_sample", sample, 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;
        step();
        chk("rst_debug", debug, 32'h0);
        run = 1'b1;

        // rate 1, shift 8: strobe every clock, 3-cycle latency
        wr(BASE + 0, 32'd1);
        wr(BASE + 1, 32'd8);
        base_strb = n_strb;
        in_i = 24'h012345; in_q = '0; in_stb = 1'b1;
        step(); chk("t1_lat1", 32'(strobe), 32'h0);
        step(); chk("t1_lat2", 32'(strobe), 32'h0);
        step(); chk("t1_first", 32'(strobe), 32'h1);
        chk("t1_sample", sample, 32'h0123_0000);
        step(); chk("t1_b2b", 32'(strobe), 32'h1);
        in_stb = 1'b0;
        repeat (4) step();
        chk("t1_count", 32'(n_strb - base_strb), 32'd4);
        chk("t1_idle", 32'(strobe), 32'h0);

        // rate 4, shift 10
        wr(BASE + 0, 32'd4);
        wr(BASE + 1, 32'd10);
        base_strb = n_strb;
        feed(8, 24'h001000, 24'h0, 0);
        repeat (4) step();
        chk("t2_count", 32'(n_strb - base_strb), 32'd2);
        chk("t2_sample", sample, 32'h0010_0000);
        chk("t2_ovf", 32'(overflow), 32'h0);

        // saturation and overflow clear
        wr(BASE + 0, 32'd4);
        wr(BASE + 1, 32'd0);
        feed(4, 24'h100000, 24'h0, 0);
        repeat (3) step();
        chk("t3_sat_hi", sample, 32'h7FFF_0000);
        chk("t3_ovf_hi", 32'(overflow), 32'h1);
        wr(BASE + 3, 32'd0);
        chk("t3_clr", 32'(overflow), 32'h0);
        feed(4, 24'h800000, 24'h0, 0);
        repeat (3) step();
        chk("t3_sat_lo", sample, 32'h8000_0000);
        chk("t3_ovf_lo", 32'(overflow), 32'h1);
        wr(BASE + 3, 32'd0);
        chk("t3_clr2", 32'(overflow), 32'h0);
        feed(4, 24'h100000, 24'h0, 0);
        step();
        wr(BASE + 3, 32'd0);
        chk("t3_setwins", 32'(overflow), 32'h1);
        chk("t3_setwins_stb", 32'(strobe), 32'h1);

        // real mode with swap; rate 0 acts like rate 1
        wr(BASE + 0, 32'd1);
        wr(BASE + 2, 32'd3);
        feed(1, 24'h000200, 24'h000400, 0);
        step(); step();
        chk("t4_stb", 32'(strobe), 32'h1);
        chk("t4_sample", sample, 32'h0400_0000);
        wr(BASE + 0, 32'd0);
        feed(1, 24'h000100, 24'h000300, 0);
        step(); step();
        chk("t4_r0_stb", 32'(strobe), 32'h1);
        chk("t4_r0_sample", sample, 32'h0300_0000);
        step();
        chk("t4_r0_single", 32'(strobe), 32'h0);
        wr(BASE + 2, 32'd0);

        // run drop flushes a partial block
        wr(BASE + 0, 32'd8);
        base_strb = n_strb;
        feed(5, 24'd100, 24'h0, 0);
        run = 1'b0;
        step();
        run = 1'b1;
        feed(7, 24'd1, 24'h0, 0);
        repeat (4) step();
        chk("t5_nostb", 32'(n_strb - base_strb), 32'd0);
        feed(1, 24'd1, 24'h0, 0);
        step(); step();
        chk("t5_stb", 32'(strobe), 32'h1);
        chk("t5_sample", sample, 32'h0008_0000);

        // gapped input, rate 2, upstream overflow
        wr(BASE + 0, 32'd2);
        wr(BASE + 3, 32'd0);
        chk("t6_clr", 32'(overflow), 32'h0);
        base_strb = n_strb;
        feed(1, 24'd3, 24'h0, 2);
        in_i = 24'd5; in_stb = 1'b1; adc_ovf_q = 1'b1;
        step();
        in_stb = 1'b0; adc_ovf_q = 1'b0;
        chk("t6_adc_ovf", 32'(overflow), 32'h1);
        step(); chk("t6_lat2", 32'(strobe), 32'h0);
        step(); chk("t6_stb", 32'(strobe), 32'h1);
        chk("t6_sample", sample, 32'h0008_0000);
`ifdef RX_OVF_COUNT_EN
        chk("t6_ovf_cnt", 32'(debug[31:16]), 32'h1);
`else
        chk("t6_debug", debug, 32'hE040_0000);
`endif
        feed(1, 24'd7, 24'h0, 2);
        feed(1, 24'd9, 24'h0, 0);
        step(); step();
        chk("t6_stb2", 32'(strobe), 32'h1);
        chk("t6_sample2", sample, 32'h0010_0000);
        repeat (3) step();
        chk("t6_count", 32'(n_strb - base_strb), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_rx_boxcar_decim.md
Name: dsp_rx_boxcar_decim

Overview:
Parametrised successor to the fixed-rate, no-decimation RX output stage.
- Takes post-mix I/Q samples, applies the I/Q swap and real-mode mux, then integrate-and-dump (boxcar) decimation at a programmable rate.
- Applies a programmable right shift, round-half-up and saturation to WIDTH_OUT bits.
- Emits strobed sample pairs with a sticky overflow status.
- Sits between the CORDIC/clip stage and the RX framer; all control is through the settings bus.

Parameters:
- WIDTH_IN, 24: signed I and Q input width.
- WIDTH_OUT, 16: signed I and Q output width.
- RATE_BITS, 8: width of the decimation-rate register; maximum rate is 2^RATE_BITS-1.
- BASE, 160: settings-bus base address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- run  in  1  enable; low flushes the block.
- in_i  in  WIDTH_IN  signed I sample.
- in_q  in  WIDTH_IN  signed Q sample.
- in_stb  in  1  input sample valid.
- adc_ovf_i  in  1  upstream I overflow, qualified by in_stb.
- adc_ovf_q  in  1  upstream Q overflow, qualified by in_stb.
- sample  out  2*WIDTH_OUT  {I,Q}, with I in the upper half.
- strobe  out  1  one-cycle valid for sample.
- overflow  out  1  sticky overflow flag.
- debug  out  32  {strobe, run, overflow, rate[RATE_BITS-1:0], zero-padded}.

Behaviour:
Settings registers:
- BASE+0: rate = set_data[RATE_BITS-1:0]; rate 0 is treated as 1.
- BASE+1: shift = set_data[4:0].
- BASE+2: {realmode, swap_iq} = set_data[1:0].
- BASE+3: any write clears overflow.
- All registers reset to 0.

Reset values: sample=0, strobe=0, overflow=0; accumulators, counter and pipeline valids are 0.

Stage 1 (mux, registered), captured when in_stb is high:
- swap_iq=1: I path takes in_q, Q path takes in_i.
- realmode=1: the Q path is forced to 0 after the swap.
- The valid bit follows in_stb.

Stage 2 (accumulate):
- Accumulators are signed, WIDTH_IN+RATE_BITS wide. Input is sign-extended; the accumulator cannot overflow.
- Counter cnt runs 0..rate-1 and advances on each stage-1 valid.
- When cnt==rate-1: register dump = acc + x, reload acc=0, cnt=0, assert stage-2 valid.
- Otherwise: acc += x, cnt++.

Stage 3 (scale, round, saturate, registered):
- r = (dump + (shift>0 ? 2^(shift-1) : 0)) >>> shift, an arithmetic shift.
- Saturate r to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
- Load sample and pulse strobe.
- sample holds its value between strobes.

Latency: strobe goes high exactly 3 clk after the in_stb cycle carrying the last sample of a block.

Overflow:
- Sets on saturation of either channel in stage 3.
- Sets on in_stb & (adc_ovf_i | adc_ovf_q).
- Clears on rst or a BASE+3 write; if a set and a clear occur in the same cycle, set wins.

run=0:
- The same cycle clears acc, cnt and all pipeline valids.
- No strobe is issued while run=0 or on the cycle run rises.
- sample keeps its last value; overflow is unaffected.

BASE+0 write: restarts the block (acc=0, cnt=0) in the write cycle. Samples already in stage 3 still emerge.

BASE+1 and BASE+2 writes take effect on the next cycle with no flush.

Back-to-back: in_stb may be high every cycle. With rate=1 this gives one strobe per clk.

Optional Feature:
Macro: RX_OVF_COUNT_EN.
- Defined: adds a 16-bit saturating counter incremented on each cycle in which overflow would be set. It holds at 0xFFFF, clears together with overflow, and replaces debug[31:16].
- Undefined: no counter is built, and debug keeps the layout above.

Test Plan:
1. rate=1, shift=8, in_i=0x012345 every cycle -> strobe every clk, first strobe 3 clk after first in_stb, I=0x0123.
2. rate=4, shift=10, in_i=0x001000 constant, in_stb continuous -> one strobe per 4 inputs, I=0x0010, overflow=0.
3. rate=4, shift=0: in_i=0x100000 -> I=0x7FFF; in_i=-0x800000 -> I=0x8000. overflow=1 in both cases; a BASE+3 write clears it; a simultaneous saturation with the BASE+3 write leaves it at 1.
4. realmode=1, swap_iq=1, in_i=0x000200, in_q=0x000400, rate=1, shift=0 -> I=0x0400, Q=0x0000. rate=0 behaves identically to rate=1.
5. rate=8, drop run for 1 cycle after 5 inputs, then resume -> no strobe until 8 fresh inputs after run returns high; the resulting sum excludes the first 5 inputs.
6. in_stb gapped (1 of 3 cycles), rate=2, in_stb=1 with adc_ovf_q=1 once -> strobes 3 clk after every 2nd accepted input, overflow=1; with RX_OVF_COUNT_EN defined, debug[31:16]=1.
